// File: rtl/lsu32_pkg.sv
// ============================================================================
// lsu32_pkg : shared funct3 encodings, FSM states and strobe constants.
// Rev 1.0
// ============================================================================
`default_nettype none

package lsu32_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  localparam logic [3:0] STRB_NONE = 4'b0000;
  localparam logic [3:0] STRB_ALL  = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/lsu_align.sv
// ============================================================================
// lsu_align : legality check, store lane strobes/replication, load extend.
// Rev 1.0
// ============================================================================
`default_nettype none

module lsu_align
  import lsu32_pkg::*;
(
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [2:0]  ld_funct3,
  input  logic [1:0]  ld_off,
  input  logic [31:0] bus_rdata,
  output logic        illegal,
  output logic [3:0]  wstrb,
  output logic [31:0] wdata_rep,
  output logic [31:0] ld_data
);

  logic        bad_f3;
  logic        misaligned;
  logic [31:0] shifted;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    bad_f3     = 1'b0;
    if (is_store) bad_f3 = !(funct3 inside {F3_SB, F3_SH, F3_SW});
    else          bad_f3 = !(funct3 inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU});
    misaligned = ((funct3[1:0] == 2'b01) && addr_lo[0]) ||
                 ((funct3[1:0] == 2'b10) && (addr_lo != 2'b00));
    illegal    = bad_f3 || misaligned;
  end

  always_comb begin
    wstrb     = STRB_NONE;
    wdata_rep = '0;
    if (is_store) begin
      case (funct3)
        F3_SB: begin
          wstrb     = 4'b0001 << addr_lo;
          wdata_rep = {4{wdata[7:0]}};
        end
        F3_SH: begin
          wstrb     = addr_lo[1] ? 4'b1100 : 4'b0011;
          wdata_rep = {2{wdata[15:0]}};
        end
        F3_SW: begin
          wstrb     = STRB_ALL;
          wdata_rep = wdata;
        end
        default: begin
          wstrb     = STRB_NONE;
          wdata_rep = '0;
        end
      endcase
    end
  end

  // Lane select uses the offset captured at request time, not the live address.
  always_comb begin
    shifted  = bus_rdata >> {ld_off, 3'b000};
    byte_sel = shifted[7:0];
    half_sel = ld_off[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    case (ld_funct3)
      F3_LB:   ld_data = {{24{byte_sel[7]}}, byte_sel};
      F3_LH:   ld_data = {{16{half_sel[15]}}, half_sel};
      F3_LBU:  ld_data = {24'd0, byte_sel};
      F3_LHU:  ld_data = {16'd0, half_sel};
      default: ld_data = bus_rdata;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/lsu32.sv
// ============================================================================
// lsu32 : RV32I load/store unit, req/ack data bus. Optional LSU_TIMEOUT_EN
// adds a WAIT-state bus-error timeout. Rev 1.0
// ============================================================================
`default_nettype none

module lsu32
  import lsu32_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              is_store,
  input  logic [2:0]        funct3,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              stall,
  output logic              done,
  output logic              fault,
  output logic [31:0]       rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_wstrb,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata
);

  state_t      state, state_next;
  logic [2:0]  ld_f3;
  logic [1:0]  ld_off;
  logic        st_op;
  logic        illegal;
  logic [3:0]  strb_c;
  logic [31:0] wrep_c;
  logic [31:0] ld_data;
  logic        timeout;

  lsu_align u_align (
    .is_store  (is_store),
    .funct3    (funct3),
    .addr_lo   (addr[1:0]),
    .wdata     (wdata),
    .ld_funct3 (ld_f3),
    .ld_off    (ld_off),
    .bus_rdata (mem_rdata),
    .illegal   (illegal),
    .wstrb     (strb_c),
    .wdata_rep (wrep_c),
    .ld_data   (ld_data)
  );

  assign stall = start & ~done;

`ifdef LSU_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] wait_cnt;

  always_ff @(posedge clk) begin
    if (rst)                             wait_cnt <= '0;
    else if (state != ST_WAIT)           wait_cnt <= '0;
    else if (!mem_ack)                   wait_cnt <= wait_cnt + 1'b1;
  end

  assign timeout = (state == ST_WAIT) && !mem_ack &&
                   (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  // Constant-false; the parameter only matters when the timeout is built.
  assign timeout = (TIMEOUT_CYCLES < 0);
`endif

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (start) state_next = illegal ? ST_DONE : ST_WAIT;
      ST_WAIT: if (mem_ack || timeout) state_next = ST_DONE;
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      done      <= 1'b0;
      fault     <= 1'b0;
      rdata     <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wstrb <= '0;
      mem_wdata <= '0;
      ld_f3     <= '0;
      ld_off    <= '0;
      st_op     <= 1'b0;
    end else begin
      state <= state_next;
      case (state)
        ST_IDLE: begin
          if (start) begin
            if (illegal) begin
              done  <= 1'b1;
              fault <= 1'b1;
              rdata <= '0;
            end else begin
              mem_req   <= 1'b1;
              mem_we    <= is_store;
              mem_addr  <= {addr[ADDR_W-1:2], 2'b00};
              mem_wstrb <= strb_c;
              mem_wdata <= wrep_c;
              ld_f3     <= funct3;
              ld_off    <= addr[1:0];
              st_op     <= is_store;
            end
          end
        end
        ST_WAIT: begin
          // Ack takes priority over a simultaneous timeout.
          if (mem_ack) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            done    <= 1'b1;
            fault   <= 1'b0;
            rdata   <= st_op ? 32'd0 : ld_data;
          end else if (timeout) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            done    <= 1'b1;
            fault   <= 1'b1;
            rdata   <= '0;
          end
        end
        default: begin
          done  <= 1'b0;
          fault <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: doc/lsu32.md
Name: lsu32

Overview:
- Load/store unit directly downstream of the 32-bit ALU in the RV32I datapath.
- Consumes the ALU result as the effective address and rs2 as store data.
- Runs a req/ack transaction on the data-memory bus, handling byte-lane alignment, write strobes and load sign/zero extension.
- Stalls the core until the access completes; result feeds the writeback mux.

Parameters:
- ADDR_W, 32, width of addr and mem_addr.
- TIMEOUT_CYCLES, 255, cycles in WAIT before a bus error (used only with LSU_TIMEOUT_EN).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  memory instruction valid; held high by the core until done.
- is_store  input  1  1 = store, 0 = load.
- funct3  input  3  RV32I load/store funct3.
- addr  input  32  effective address (ALU result).
- wdata  input  32  store data (rs2).
- stall  output  1  start & ~done (combinational).
- done  output  1  one-cycle completion pulse.
- fault  output  1  one-cycle pulse: misaligned, illegal funct3 or bus error; coincides with done.
- rdata  output  32  extended load result, valid when done.
- mem_req  output  1  bus request.
- mem_we  output  1  write enable.
- mem_addr  output  32  word-aligned address ({addr[31:2],2'b00}).
- mem_wstrb  output  4  byte strobes.
- mem_wdata  output  32  lane-replicated store data.
- mem_ack  input  1  bus completion; rdata valid on loads.
- mem_rdata  input  32  bus read data.

Behaviour:
- FSM states IDLE, WAIT, DONE.
- IDLE -> WAIT on start when the access is legal; operands and lane info are registered in this transition.
- IDLE -> DONE on start when illegal; fault=1, no bus cycle.
- WAIT -> DONE on mem_ack; load data is extracted and captured on that edge.
- DONE -> IDLE unconditionally.
- Legal funct3: loads 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores 000 SB, 001 SH, 010 SW. Any other funct3 is illegal.
- Misaligned: halfword with addr[0]=1; word with addr[1:0]!=0.
- Outputs are registered. mem_req=1 only in WAIT. mem_we/addr/wstrb/wdata are stable for all of WAIT.
- Latency: start seen at edge N, mem_req high cycle N+1. Ack in cycle N+k gives done in cycle N+k+1. Minimum 2 cycles.
- Store lanes:
  - SB: wstrb=4'b0001<<addr[1:0]; wdata byte replicated x4.
  - SH: wstrb=0011 (addr[1]=0) or 1100; halfword replicated x2.
  - SW: wstrb=1111.
- Loads: wstrb=0000. Data is selected by addr[1:0] (byte) or addr[1] (half), then sign-extended (LB/LH) or zero-extended (LBU/LHU).
- rdata holds its value until the next load completes. It is 0 after stores and faults.
- start is ignored outside IDLE. mem_ack outside WAIT is ignored.
- Reset values: state IDLE; done, fault, mem_req, mem_we = 0; mem_addr, mem_wstrb, mem_wdata, rdata = 0.
- Reset mid-WAIT drops mem_req at that edge; a late ack is ignored.

Optional Feature:
- Macro LSU_TIMEOUT_EN.
- Defined:
  - A cycle counter is cleared on WAIT entry and increments each WAIT cycle without ack.
  - At TIMEOUT_CYCLES it forces DONE with fault=1 and rdata=0, and drops mem_req.
  - If ack and timeout occur in the same cycle, ack wins.
- Undefined: WAIT waits indefinitely; no counter logic is built.

Decomposition:
- Shared header: funct3 encodings (F3_LB…F3_SW), FSM state encodings, mask/width constants.
- Sub-module lsu_align: combinational store strobe/replication, load extract/extend, misalign/illegal detect. lsu32 holds the FSM and registers.

Test Plan:
- SW to 0x100 with wdata 0xDEADBEEF, ack on 1st WAIT cycle -> mem_addr=0x100, wstrb=1111, wdata=0xDEADBEEF, done at cycle 2, fault=0.
- SB to 0x103 with wdata 0x000000A5 -> wstrb=1000, mem_wdata=0xA5A5A5A5, mem_addr=0x100.
- LB vs LBU from 0x202, mem_rdata=0x1280FF34 -> LB rdata=0xFFFFFF80, LBU rdata=0x00000080; LH from 0x202 -> 0x00001280.
- LW from 0x101 -> no mem_req, done+fault next cycle. funct3=011 load -> same result.
- Ack delayed 5 cycles, then rst in WAIT cycle 3 -> mem_req 0 after the edge, state IDLE, late ack produces no done.
- With LSU_TIMEOUT_EN and TIMEOUT_CYCLES=4, no ack -> done+fault after 4 WAIT cycles, rdata=0.
